echo_cancel_sequencer: RTL and testbench
========================================

# echo_cancel_sequencer

Parametrised, FSM-driven control sequencer for the echo-cancellation datapath, serving N_CH channel pairs (send/lag) time-multiplexed per sample period. Per channel it runs 16-bit-to-double conversion, optional NLMS parameter adaptation, echo cancellation and double-to-16-bit output through explicit start/done handshakes with per-stage timeouts. It has no fixed-delay waits. It sits between the sample front end and shared arithmetic units (converter, para-approx, canceller, output converter). It keeps a separate adaptation iteration count for each channel.

## Interface
- N_CH, 2, channel count (1..8); CHW = max(1, clog2(N_CH))
- ITER_W, 13, iteration counter width
- TIMEOUT, 1023, max cycles a stage may wait for done
- clk_operation  in  1  operation clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  accept sample strobes
- sample_strobe  in  1  one-cycle pulse marking a new sample period
- sig16b  in  16*N_CH  send samples; channel c at [16c+15:16c]
- sig16b_lag  in  16*N_CH  received (echo) samples, same packing
- set_max_iteration  in  ITER_W  adaptation limit per channel
- mode  in  2  0 auto (adapt while iteration < limit), 1 always adapt, 2 freeze, 3 treated as 2
- ch  out  CHW  channel currently in service
- cvt_start/cvt_done  out/in  1  converter handshake; cvt_sig, cvt_lag out 16; cvt_sig_d, cvt_lag_d in 64
- adp_start/adp_done  out/in  1  adaptation handshake; adp_sig, adp_lag out 64; adp_e in 64
- can_start/can_done  out/in  1  cancellation handshake; can_sig, can_lag out 64; can_out in 64
- out_start  out  1  one-cycle launch of output conversion; out_d out 64
- iteration  out  ITER_W*N_CH  per-channel adaptation counts
- busy  out  1  FSM not in IDLE
- overrun, timeout_err  out  1  sticky error flags

## Operation
- States: IDLE, CVT, ADAPT, CANCEL, EMIT, NEXT.
- IDLE: on sample_strobe && enable, latch all N_CH sample pairs, set ch=0, go to CVT.
- On every entry to CVT, ADAPT or CANCEL, the matching *_start pulses for exactly one cycle and the stage timer clears.
- CVT: on cvt_done, register cvt_sig_d/cvt_lag_d into adp_*/can_*. Then decide adapt = (mode==1) || (mode==0 && iteration[ch] < set_max_iteration). Go to ADAPT if adapt is true, else go to CANCEL.
- ADAPT: on adp_done, register adp_e and go to CANCEL.
- CANCEL: on can_done, go to EMIT.
- EMIT (one cycle): out_start=1. out_d = registered adp_e if the channel adapted, else can_out. If the channel adapted, iteration[ch] increments, saturating at 2^ITER_W-1.
- NEXT: if ch==N_CH-1 go to IDLE, else ch+1 and go to CVT.
- Timeout: if done is still absent after TIMEOUT cycles in a stage, set timeout_err. The channel is abandoned (no out_start, no increment) and the FSM goes to NEXT.
- A done input is ignored outside its own state and in the cycle its start is asserted.
- A sample_strobe while busy sets overrun and is otherwise ignored; latched samples are not overwritten.
- enable deasserting mid-sample: the current sample period completes; later strobes are ignored.
- set_max_iteration and mode are sampled only at cvt_done.

## Timing
- Reset values: all outputs 0, state IDLE, ch 0, iteration all 0, sticky flags cleared. rst mid-operation aborts immediately.
- Strobe in cycle t gives cvt_start in t+1.
- Stage transitions occur the cycle after done; the next start follows on entry.
- Sequencer overhead per channel: 4 cycles without adaptation (CVT, CANCEL, EMIT, NEXT entries), 5 with adaptation, plus the external latencies.
- Required sample period ≥ N_CH × (overhead + converter + adaptation + canceller latency).

## Structure
- Package echo_seq_pkg holds the state enum, mode encoding constants, DBL_W=64 and SIG_W=16.
- One sub-module, echo_stage_timer, provides the clearable saturating counter with a timeout flag at TIMEOUT.
- Per-channel iteration registers live in a generate loop.

## Test plan
- N_CH=2, mode 0, limit 3, fast stubs (done after 5 cycles): first 3 strobes adapt and emit adp_e; from strobe 4 on, the output is can_out; iteration = {3,3}.
- Mode 2 with limit 100: no adp_start pulses ever occur, iteration stays 0, and out_start fires twice per strobe.
- Withhold adp_done on ch0 with TIMEOUT=1023: at cycle 1023 in ADAPT, timeout_err=1 and there is no out_start for ch0. ch1 is processed normally.
- Second strobe while busy: overrun=1 and the latched samples are unchanged. The second strobe after return to IDLE is accepted.
- rst asserted during CANCEL: next cycle all outputs are 0 and busy=0. A strobe afterwards restarts at ch0 with iteration cleared.
- Spurious can_done in CVT: ignored, and the state remains CVT until cvt_done.

Source files
------------

// File: rtl/echo_cancel_sequencer_pkg.sv
// Shared types and constants for the echo-cancellation control sequencer.
package echo_seq_pkg;
  localparam int SIG_W = 16;
  localparam int DBL_W = 64;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_ALWAYS = 2'd1;
  localparam logic [1:0] MODE_FREEZE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CVT,
    S_ADAPT,
    S_CANCEL,
    S_EMIT,
    S_NEXT
  } state_e;

  // Adaptation decision for one channel; encoding 3 behaves like freeze.
  function automatic logic do_adapt(input logic [1:0] mode, input logic below_limit);
    case (mode)
      MODE_ALWAYS: return 1'b1;
      MODE_AUTO:   return below_limit;
      MODE_FREEZE: return 1'b0;
      default:     return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/echo_cancel_sequencer_if.sv
// Start/done handshakes and operand buses between the sequencer and the
// shared arithmetic units (converter, para-approx, canceller, output cvt).
interface echo_cancel_sequencer_if;
  import echo_seq_pkg::*;

  logic             cvt_start;
  logic             cvt_done;
  logic [SIG_W-1:0] cvt_sig;
  logic [SIG_W-1:0] cvt_lag;
  logic [DBL_W-1:0] cvt_sig_d;
  logic [DBL_W-1:0] cvt_lag_d;

  logic             adp_start;
  logic             adp_done;
  logic [DBL_W-1:0] adp_sig;
  logic [DBL_W-1:0] adp_lag;
  logic [DBL_W-1:0] adp_e;

  logic             can_start;
  logic             can_done;
  logic [DBL_W-1:0] can_sig;
  logic [DBL_W-1:0] can_lag;
  logic [DBL_W-1:0] can_out;

  logic             out_start;
  logic [DBL_W-1:0] out_d;

  modport master (
    output cvt_start, cvt_sig, cvt_lag,
    output adp_start, adp_sig, adp_lag,
    output can_start, can_sig, can_lag,
    output out_start, out_d,
    input  cvt_done, cvt_sig_d, cvt_lag_d,
    input  adp_done, adp_e,
    input  can_done, can_out
  );

  modport slave (
    input  cvt_start, cvt_sig, cvt_lag,
    input  adp_start, adp_sig, adp_lag,
    input  can_start, can_sig, can_lag,
    input  out_start, out_d,
    output cvt_done, cvt_sig_d, cvt_lag_d,
    output adp_done, adp_e,
    output can_done, can_out
  );
endinterface

// File: rtl/echo_stage_timer.sv
// Clearable saturating cycle counter; expired is high in the TIMEOUT-th
// cycle after a clear, so a stage gives up after TIMEOUT cycles without done.
module echo_stage_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Count up from zero after a clear, holding at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                        cnt_d = '0;
    else if (cnt_q != TW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q >= TW'(TIMEOUT - 1));
endmodule

// File: rtl/echo_cancel_sequencer.sv
// Per-sample sequencer: walks each channel pair through convert, optional
// NLMS adaptation, cancellation and output launch using start/done handshakes.
module echo_cancel_sequencer
  import echo_seq_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ITER_W  = 13,
  parameter int TIMEOUT = 1023,
  localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk_operation,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sample_strobe,
  input  logic [SIG_W*N_CH-1:0]   sig16b,
  input  logic [SIG_W*N_CH-1:0]   sig16b_lag,
  input  logic [ITER_W-1:0]       set_max_iteration,
  input  logic [1:0]              mode,
  output logic [CHW-1:0]          ch,
  output logic [ITER_W*N_CH-1:0]  iteration,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err,
  echo_cancel_sequencer_if.master arith
);
  state_e                       state_q, state_d;
  logic [CHW-1:0]               ch_q, ch_d;
  logic [N_CH-1:0][SIG_W-1:0]   sig_q, sig_d, lag_q, lag_d;
  logic [DBL_W-1:0]             dsig_q, dsig_d, dlag_q, dlag_d;
  logic [DBL_W-1:0]             adp_e_q, adp_e_d, out_d_q, out_d_d;
  logic                         adapt_q, adapt_d;
  logic                         cvt_start_q, cvt_start_d, adp_start_q, adp_start_d;
  logic                         can_start_q, can_start_d, out_start_q, out_start_d;
  logic                         overrun_q, overrun_d, tmo_q, tmo_d;
  logic                         tmr_clr, tmr_exp, inc_en;
  logic [ITER_W-1:0]            iter_cur [N_CH];

  // Next-state, datapath capture and sticky error logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sig_d     = sig_q;
    lag_d     = lag_q;
    dsig_d    = dsig_q;
    dlag_d    = dlag_q;
    adp_e_d   = adp_e_q;
    out_d_d   = out_d_q;
    adapt_d   = adapt_q;
    overrun_d = overrun_q;
    tmo_d     = tmo_q;
    out_start_d = 1'b0;
    inc_en    = 1'b0;
    if (sample_strobe && state_q != S_IDLE) overrun_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (sample_strobe && enable) begin
          sig_d   = sig16b;
          lag_d   = sig16b_lag;
          ch_d    = '0;
          state_d = S_CVT;
        end
      end
      // A done raised in the same cycle as its start is not trusted.
      S_CVT: begin
        if (arith.cvt_done && !cvt_start_q) begin
          dsig_d  = arith.cvt_sig_d;
          dlag_d  = arith.cvt_lag_d;
          adapt_d = do_adapt(mode, iter_cur[ch_q] < set_max_iteration);
          state_d = do_adapt(mode, iter_cur[ch_q] < set_max_iteration) ? S_ADAPT : S_CANCEL;
        end else if (tmr_exp) begin
          tmo_d   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_ADAPT: begin
        if (arith.adp_done && !adp_start_q) begin
          adp_e_d = arith.adp_e;
          state_d = S_CANCEL;
        end else if (tmr_exp) begin
          tmo_d   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_CANCEL: begin
        if (arith.can_done && !can_start_q) begin
          out_d_d     = adapt_q ? adp_e_q : arith.can_out;
          out_start_d = 1'b1;
          state_d     = S_EMIT;
        end else if (tmr_exp) begin
          tmo_d   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_EMIT: begin
        inc_en  = adapt_q;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (ch_q == CHW'(N_CH - 1)) begin
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_CVT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cvt_start_d = (state_d == S_CVT)    && (state_q != S_CVT);
    adp_start_d = (state_d == S_ADAPT)  && (state_q != S_ADAPT);
    can_start_d = (state_d == S_CANCEL) && (state_q != S_CANCEL);
  end

  // Every state change restarts the stage timer.
  assign tmr_clr = (state_d != state_q);

  echo_stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk_operation),
    .rst     (rst),
    .clr     (tmr_clr),
    .expired (tmr_exp)
  );

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      sig_q       <= '0;
      lag_q       <= '0;
      dsig_q      <= '0;
      dlag_q      <= '0;
      adp_e_q     <= '0;
      out_d_q     <= '0;
      adapt_q     <= 1'b0;
      cvt_start_q <= 1'b0;
      adp_start_q <= 1'b0;
      can_start_q <= 1'b0;
      out_start_q <= 1'b0;
      overrun_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      sig_q       <= sig_d;
      lag_q       <= lag_d;
      dsig_q      <= dsig_d;
      dlag_q      <= dlag_d;
      adp_e_q     <= adp_e_d;
      out_d_q     <= out_d_d;
      adapt_q     <= adapt_d;
      cvt_start_q <= cvt_start_d;
      adp_start_q <= adp_start_d;
      can_start_q <= can_start_d;
      out_start_q <= out_start_d;
      overrun_q   <= overrun_d;
      tmo_q       <= tmo_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_iter
    logic [ITER_W-1:0] it_q, it_d;

    // Saturating adaptation count, bumped in EMIT of an adapted channel.
    always_comb begin
      it_d = it_q;
      if (inc_en && ch_q == CHW'(c) && it_q != '1) it_d = it_q + 1'b1;
    end

    // Iteration register for this channel.
    always_ff @(posedge clk_operation) begin
      if (rst) it_q <= '0;
      else     it_q <= it_d;
    end

    assign iter_cur[c]                    = it_q;
    assign iteration[ITER_W*c +: ITER_W] = it_q;
  end

  assign arith.cvt_start = cvt_start_q;
  assign arith.cvt_sig   = sig_q[ch_q];
  assign arith.cvt_lag   = lag_q[ch_q];
  assign arith.adp_start = adp_start_q;
  assign arith.adp_sig   = dsig_q;
  assign arith.adp_lag   = dlag_q;
  assign arith.can_start = can_start_q;
  assign arith.can_sig   = dsig_q;
  assign arith.can_lag   = dlag_q;
  assign arith.out_start = out_start_q;
  assign arith.out_d     = out_d_q;

  assign ch          = ch_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = tmo_q;
endmodule

// File: tb/tb_echo_cancel_sequencer.sv
// Bench for echo_cancel_sequencer: stub arithmetic units answer each start
// with random results; a per-sample model predicts emissions and counts.
module tb_echo_cancel_sequencer;
  import echo_seq_pkg::*;

  localparam int N_CH = 2, ITER_W = 13, TIMEOUT = 1023, LAT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, enable, sample_strobe;
  logic [16*N_CH-1:0]     sig16b, sig16b_lag;
  logic [ITER_W-1:0]      set_max_iteration;
  logic [1:0]             mode;
  logic [0:0]             ch;
  logic [ITER_W*N_CH-1:0] iteration;
  logic                   busy, overrun, timeout_err;

  echo_cancel_sequencer_if ifc ();

  echo_cancel_sequencer #(.N_CH(N_CH), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_operation     (clk),
    .rst               (rst),
    .enable            (enable),
    .sample_strobe     (sample_strobe),
    .sig16b            (sig16b),
    .sig16b_lag        (sig16b_lag),
    .set_max_iteration (set_max_iteration),
    .mode              (mode),
    .ch                (ch),
    .iteration         (iteration),
    .busy              (busy),
    .overrun           (overrun),
    .timeout_err       (timeout_err),
    .arith             (ifc)
  );

  typedef struct { int ch; logic [63:0] d; } emit_t;

  int checks = 0, failures = 0;
  int iter_m [N_CH];
  logic [15:0] s_sig [N_CH], s_lag [N_CH];

  // stub state and observations
  int cvt_cnt = 0, adp_cnt = 0, can_cnt = 0, spur_cnt = 0;
  bit hold_adp0 = 0, spurious_can = 0, tmo_prev = 0;
  int cyc_n = 0, adp0_cyc = 0, tmo_cyc = -1;
  int n_cvt_start = 0, n_adp_start = 0, order_err = 0;
  bit cvt_ok [N_CH];
  logic [63:0] r_cvt_sig [N_CH], r_cvt_lag [N_CH], r_adp_e [N_CH], r_can_out [N_CH];
  logic [63:0] seen_adp_sig [N_CH], seen_can_lag [N_CH];
  logic [15:0] seen_cvt_sig [N_CH], seen_cvt_lag [N_CH];
  emit_t emits [$];

  // Stub arithmetic units plus output monitor, all on the falling edge.
  always @(negedge clk) begin
    int c;
    emit_t e;
    c = int'(ch);
    cyc_n++;
    ifc.cvt_done = 1'b0;
    ifc.adp_done = 1'b0;
    ifc.can_done = 1'b0;
    if (timeout_err === 1'b1 && !tmo_prev) tmo_cyc = cyc_n;
    tmo_prev = (timeout_err === 1'b1);
    if (rst === 1'b1) begin
      cvt_cnt = 0; adp_cnt = 0; can_cnt = 0; spur_cnt = 0;
    end else begin
      if (ifc.out_start === 1'b1) begin
        e.ch = c; e.d = ifc.out_d; emits.push_back(e);
      end
      if (ifc.cvt_start === 1'b1) begin
        n_cvt_start++;
        cvt_ok[c] = 1'b0;
        seen_cvt_sig[c] = ifc.cvt_sig;
        seen_cvt_lag[c] = ifc.cvt_lag;
        cvt_cnt = spurious_can ? LAT + 4 : LAT;
        if (spurious_can) spur_cnt = 2;
      end else if (cvt_cnt > 0) begin
        cvt_cnt--;
        if (cvt_cnt == 0) begin
          ifc.cvt_done  = 1'b1;
          ifc.cvt_sig_d = {$urandom, $urandom};
          ifc.cvt_lag_d = {$urandom, $urandom};
          r_cvt_sig[c] = ifc.cvt_sig_d;
          r_cvt_lag[c] = ifc.cvt_lag_d;
          cvt_ok[c] = 1'b1;
        end
      end
      if (spur_cnt > 0) begin
        spur_cnt--;
        if (spur_cnt == 0) begin
          ifc.can_done = 1'b1;
          ifc.can_out  = {$urandom, $urandom};
        end
      end
      if (ifc.adp_start === 1'b1) begin
        n_adp_start++;
        if (!cvt_ok[c]) order_err++;
        if (c == 0) adp0_cyc = cyc_n;
        seen_adp_sig[c] = ifc.adp_sig;
        if (!(hold_adp0 && c == 0)) adp_cnt = LAT;
      end else if (adp_cnt > 0) begin
        adp_cnt--;
        if (adp_cnt == 0) begin
          ifc.adp_done = 1'b1;
          ifc.adp_e    = {$urandom, $urandom};
          r_adp_e[c]   = ifc.adp_e;
        end
      end
      if (ifc.can_start === 1'b1) begin
        if (!cvt_ok[c]) order_err++;
        seen_can_lag[c] = ifc.can_lag;
        can_cnt = LAT;
      end else if (can_cnt > 0) begin
        can_cnt--;
        if (can_cnt == 0) begin
          ifc.can_done = 1'b1;
          ifc.can_out  = {$urandom, $urandom};
          r_can_out[c] = ifc.can_out;
        end
      end
    end
  end

  // One sample period end to end, checked against the model.
  task automatic run_sample(input logic [1:0] md, input int lim, input bit ovr,
                            input bit tmo0, input bit drop_en);
    bit adapt [N_CH];
    int cyc, k, n_adp_exp;
    logic [63:0] exp_d;
    logic [ITER_W*N_CH-1:0] exp_it;
    mode = md;
    set_max_iteration = ITER_W'(lim);
    emits.delete();
    n_adp_start = 0;
    n_adp_exp = 0;
    for (int c = 0; c < N_CH; c++) begin
      s_sig[c] = 16'($urandom);
      s_lag[c] = 16'($urandom);
      sig16b[16*c +: 16]     = s_sig[c];
      sig16b_lag[16*c +: 16] = s_lag[c];
      adapt[c] = (md == 2'd1) || (md == 2'd0 && iter_m[c] < lim);
      if (adapt[c]) n_adp_exp++;
    end
    @(negedge clk); sample_strobe = 1'b1;
    @(negedge clk); sample_strobe = 1'b0;
    if (drop_en) enable = 1'b0;
    checks++;
    if (ifc.cvt_start !== 1'b1 || ch !== 1'b0) begin
      failures++;
      $display("FAIL strobe_to_cvt_start: cvt_start=%b ch=%0d, expected 1 and 0", ifc.cvt_start, ch);
    end
    if (ovr) begin
      repeat (3) @(negedge clk);
      sig16b = ~sig16b;
      sig16b_lag = ~sig16b_lag;
      sample_strobe = 1'b1;
      @(negedge clk); sample_strobe = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
        failures++;
        $display("FAIL overrun_flag: got %b, expected 1", overrun);
      end
    end
    cyc = 0;
    while (busy !== 1'b0 && cyc < 3000) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc >= 3000) begin
      failures++;
      $display("FAIL busy_wait: still busy after %0d cycles", cyc);
    end
    k = 0;
    for (int c = 0; c < N_CH; c++) begin
      checks++;
      if (seen_cvt_sig[c] !== s_sig[c] || seen_cvt_lag[c] !== s_lag[c]) begin
        failures++;
        $display("FAIL cvt_operands ch%0d: got %h/%h, expected %h/%h", c,
                 seen_cvt_sig[c], seen_cvt_lag[c], s_sig[c], s_lag[c]);
      end
      if (!(tmo0 && c == 0)) begin
        exp_d = adapt[c] ? r_adp_e[c] : r_can_out[c];
        checks++;
        if (k >= emits.size()) begin
          failures++;
          $display("FAIL emit_missing ch%0d: got %0d emissions, expected out_d %h", c, emits.size(), exp_d);
        end else if (emits[k].ch != c || emits[k].d !== exp_d) begin
          failures++;
          $display("FAIL emit_value: got ch%0d %h, expected ch%0d %h", emits[k].ch, emits[k].d, c, exp_d);
        end
        k++;
        checks++;
        if (seen_can_lag[c] !== r_cvt_lag[c] || (adapt[c] && seen_adp_sig[c] !== r_cvt_sig[c])) begin
          failures++;
          $display("FAIL stage_operands ch%0d: can_lag %h adp_sig %h, expected %h %h", c,
                   seen_can_lag[c], seen_adp_sig[c], r_cvt_lag[c], r_cvt_sig[c]);
        end
        if (adapt[c] && iter_m[c] < (1 << ITER_W) - 1) iter_m[c]++;
      end
    end
    checks++;
    if (emits.size() != k) begin
      failures++;
      $display("FAIL emit_count: got %0d, expected %0d", emits.size(), k);
    end
    checks++;
    if (n_adp_start != n_adp_exp) begin
      failures++;
      $display("FAIL adp_start_count: got %0d, expected %0d", n_adp_start, n_adp_exp);
    end
    for (int c = 0; c < N_CH; c++) exp_it[ITER_W*c +: ITER_W] = ITER_W'(iter_m[c]);
    checks++;
    if (iteration !== exp_it) begin
      failures++;
      $display("FAIL iteration: got %h, expected %h", iteration, exp_it);
    end
    checks++;
    if (order_err != 0) begin
      failures++;
      $display("FAIL stage_order: %0d stage starts before conversion done, expected 0", order_err);
    end
    order_err = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < N_CH; c++) iter_m[c] = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; sample_strobe = 1'b0;
    sig16b = '0; sig16b_lag = '0; set_max_iteration = '0; mode = 2'd0;
    for (int c = 0; c < N_CH; c++) iter_m[c] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.cvt_start, ifc.adp_start, ifc.can_start, ifc.out_start, ifc.out_d,
         ch, iteration, busy, overrun, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b ch=%0d iter=%h out_d=%h, expected all 0",
               busy, ch, iteration, ifc.out_d);
    end
  endtask

  task automatic test_freeze();
    pulse_reset();
    run_sample(2'd2, 100, 0, 0, 0);
    run_sample(2'd2, 100, 0, 0, 0);
    run_sample(2'd3, 100, 0, 0, 0);
    checks++;
    if (iteration !== '0) begin
      failures++;
      $display("FAIL freeze_iteration: got %h, expected 0", iteration);
    end
  endtask

  task automatic test_auto_adapt();
    for (int i = 0; i < 5; i++) run_sample(2'd0, 3, 0, 0, 0);
    checks++;
    if (iteration !== {13'd3, 13'd3}) begin
      failures++;
      $display("FAIL auto_limit: got %h, expected {3,3}", iteration);
    end
  endtask

  task automatic test_always();
    run_sample(2'd1, 0, 0, 0, 0);
    run_sample(2'd1, 2, 0, 0, 0);
  endtask

  task automatic test_enable();
    int n;
    run_sample(2'd2, 0, 0, 0, 1);
    n = n_cvt_start;
    @(negedge clk); sample_strobe = 1'b1;
    @(negedge clk); sample_strobe = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_cvt_start != n) begin
      failures++;
      $display("FAIL strobe_while_disabled: busy=%b cvt_starts=%0d, expected 0 and %0d", busy, n_cvt_start, n);
    end
    enable = 1'b1;
  endtask

  task automatic test_timeout();
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pre: got %b, expected 0", timeout_err);
    end
    hold_adp0 = 1'b1;
    tmo_cyc = -1;
    run_sample(2'd1, 0, 0, 1, 0);
    hold_adp0 = 1'b0;
    checks++;
    if (timeout_err !== 1'b1 || tmo_cyc - adp0_cyc != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_timing: err=%b after %0d cycles, expected 1 after %0d",
               timeout_err, tmo_cyc - adp0_cyc, TIMEOUT);
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_pre: got %b, expected 0", overrun);
    end
    run_sample(2'd1, 0, 1, 0, 0);
    run_sample(2'd0, 0, 0, 0, 0);
  endtask

  task automatic test_spurious();
    spurious_can = 1'b1;
    run_sample(2'd2, 0, 0, 0, 0);
    run_sample(2'd1, 0, 0, 0, 0);
    spurious_can = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    mode = 2'd2;
    @(negedge clk); sample_strobe = 1'b1;
    @(negedge clk); sample_strobe = 1'b0;
    cyc = 0;
    while (ifc.can_start !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc >= 200) begin
      failures++;
      $display("FAIL can_start_wait: no can_start within %0d cycles", cyc);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.cvt_start, ifc.adp_start, ifc.can_start, ifc.out_start, ifc.out_d, ifc.cvt_sig,
         ifc.cvt_lag, ifc.adp_sig, ifc.can_lag, ch, iteration, busy, overrun, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b ch=%0d iter=%h ovr=%b tmo=%b, expected all 0",
               busy, ch, iteration, overrun, timeout_err);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < N_CH; c++) iter_m[c] = 0;
    run_sample(2'd0, 3, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_freeze();
    test_auto_adapt();
    test_always();
    test_enable();
    test_timeout();
    test_overrun();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
